// File: rtl/vga_timing_monitor.sv
// Passive VGA sync checker: rebuilds the raster position from hsync/vsync,
// verifies line/frame timing, reports lock, frame count and sticky errors.
module vga_timing_monitor #(
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_START  = 144,
   parameter int unsigned H_END    = 784,
   parameter int unsigned V_TOTAL  = 521,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_START  = 31,
   parameter int unsigned V_END    = 511,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       pix_en,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       err_clr,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       locked,
   output logic [7:0] frame_cnt,
   output logic       err_h,
   output logic       err_v
);

   localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
   localparam logic [9:0] HS_M1 = 10'(H_SYNC - 1);
   localparam logic [9:0] HST   = 10'(H_START);
   localparam logic [9:0] HEN   = 10'(H_END);
   localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
   localparam logic [9:0] VS_W  = 10'(V_SYNC);
   localparam logic [9:0] VST   = 10'(V_START);
   localparam logic [9:0] VEN   = 10'(V_END);

   typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

   state_t     state, state_nxt;
   logic       hs, vs, hs_d, vs_d;
   logic       hs_fall, hs_rise, vs_fall, vs_rise;
   logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
   logic       line_e, frame_e, frame_inc;
   logic       active_nxt;
   logic [9:0] x_nxt, y_nxt;

   assign hs      = (hsync == SYNC_POL);
   assign vs      = (vsync == SYNC_POL);
   assign hs_fall = hs & ~hs_d;
   assign hs_rise = ~hs & hs_d;
   assign vs_fall = vs & ~vs_d;
   assign vs_rise = ~vs & vs_d;

   assign hcnt_nxt = hs_fall ? '0 : ((hcnt == '1) ? hcnt : hcnt + 10'd1);
   assign vcnt_nxt = vs_fall ? '0 :
                     (hs_fall ? ((vcnt == '1) ? vcnt : vcnt + 10'd1) : vcnt);

   // Falls are judged on the count that just ended; the vsync rise lands on
   // an hsync fall, so it is judged on the already-advanced line count.
   assign line_e  = (state != SEARCH) &&
                    ((hs_fall && hcnt != HT_M1) ||
                     (hs_rise && hcnt != HS_M1) ||
                     (hcnt_nxt == '1));
   assign frame_e = (state == LOCKED) &&
                    ((vs_fall && vcnt != VT_M1) ||
                     (vs_rise && vcnt_nxt != VS_W) ||
                     (vs_fall && !hs_fall) ||
                     (vcnt_nxt == '1));
   assign frame_inc = (state == LOCKED) && vs_fall && !line_e && !frame_e;

   always_ff @(posedge clk) begin
      if (!clr)
         state <= SEARCH;
      else if (pix_en)
         state <= state_nxt;
   end

   // An error sample that is itself an hsync fall restarts acquisition directly.
   always_comb begin
      state_nxt = state;
      case (state)
         SEARCH: if (hs_fall) state_nxt = H_ACQ;
         H_ACQ: begin
            if (line_e)       state_nxt = hs_fall ? H_ACQ : SEARCH;
            else if (hs_fall) state_nxt = V_ACQ;
         end
         V_ACQ: begin
            if (line_e)                  state_nxt = hs_fall ? H_ACQ : SEARCH;
            else if (vs_fall && hs_fall) state_nxt = LOCKED;
         end
         LOCKED: if (line_e || frame_e) state_nxt = hs_fall ? H_ACQ : SEARCH;
         default: state_nxt = SEARCH;
      endcase
   end

   always_comb begin
      active_nxt = (state_nxt == LOCKED) &&
                   (hcnt_nxt >= HST) && (hcnt_nxt < HEN) &&
                   (vcnt_nxt >= VST) && (vcnt_nxt < VEN);
      x_nxt = '0;
      y_nxt = '0;
      if (active_nxt) begin
         x_nxt = hcnt_nxt - HST;
         y_nxt = vcnt_nxt - VST;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         hcnt      <= '0;
         vcnt      <= '0;
         hs_d      <= 1'b0;
         vs_d      <= 1'b0;
         x         <= '0;
         y         <= '0;
         active    <= 1'b0;
         frame_cnt <= '0;
         err_h     <= 1'b0;
         err_v     <= 1'b0;
      end else if (pix_en) begin
         hcnt   <= hcnt_nxt;
         vcnt   <= vcnt_nxt;
         hs_d   <= hs;
         vs_d   <= vs;
         x      <= x_nxt;
         y      <= y_nxt;
         active <= active_nxt;
         if (frame_inc)
            frame_cnt <= frame_cnt + 8'd1;
         if (line_e)       err_h <= 1'b1;
         else if (err_clr) err_h <= 1'b0;
         if (frame_e)      err_v <= 1'b1;
         else if (err_clr) err_v <= 1'b0;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 40x20 raster so whole
// frames fit in a short run; pix_en strobes every second clk.
module tb_vga_timing_monitor;

   localparam int HT  = 40;
   localparam int HS  = 6;
   localparam int HST = 10;
   localparam int HEN = 36;
   localparam int VT  = 20;
   localparam int VS  = 2;
   localparam int VST = 4;
   localparam int VEN = 18;
   localparam int BUDGET = HT * VT + 1;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       pix_en = 1'b0;
   logic       hsync = 1'b1;
   logic       vsync = 1'b1;
   logic       err_clr = 1'b0;
   logic [9:0] x, y;
   logic       active, locked, err_h, err_v;
   logic [7:0] frame_cnt;

   always #5 clk = ~clk;

   vga_timing_monitor #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HEN),
      .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VEN),
      .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .clr(clr), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
      .err_clr(err_clr), .x(x), .y(y), .active(active), .locked(locked),
      .frame_cnt(frame_cnt), .err_h(err_h), .err_v(err_v)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int hc = 17, vc = 3;
   int last_h = -1, last_v = -1;
   int line_len = HT, frame_len = VT, hs_w = HS;
   logic vs_glitch = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // One pixel: strobe pix_en for a single clk, outputs are valid on return.
   task automatic step();
      @(negedge clk);
      pix_en = 1'b1;
      hsync  = (hc < hs_w) ? 1'b0 : 1'b1;
      vsync  = (vc < VS || vs_glitch) ? 1'b0 : 1'b1;
      last_h = hc;
      last_v = vc;
      @(negedge clk);
      pix_en = 1'b0;
      hc++;
      if (hc >= line_len) begin
         hc = 0; line_len = HT; hs_w = HS; vc++;
         if (vc >= frame_len) begin
            vc = 0; frame_len = VT;
         end
      end
   endtask

   task automatic advance_to(input int h, input int v);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(last_h == h && last_v == v) && n < BUDGET);
      if (!(last_h == h && last_v == v))
         check("reach", last_v * 1024 + last_h, v * 1024 + h);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_locked", int'(locked), 0);
      check("rst_active", int'(active), 0);
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_frame", int'(frame_cnt), 0);
      check("rst_err_h", int'(err_h), 0);
      check("rst_err_v", int'(err_v), 0);
      clr = 1'b1;

      // Acquisition from mid-line: hs fall (0,4), good line (0,5), frame (0,0)
      advance_to(39, 19);
      check("pre_lock", int'(locked), 0);
      step();
      check("lock", int'(locked), 1);
      check("lock_frame", int'(frame_cnt), 0);
      advance_to(HST, VST);
      check("first_act", int'(active), 1);
      check("first_x", int'(x), 0);
      check("first_y", int'(y), 0);
      advance_to(HEN - 1, VEN - 1);
      check("last_x", int'(x), HEN - HST - 1);
      check("last_y", int'(y), VEN - VST - 1);
      check("last_act", int'(active), 1);
      step();
      check("h_end_act", int'(active), 0);
      check("h_end_x", int'(x), 0);
      advance_to(0, 0);
      advance_to(0, 0);
      advance_to(0, 0);
      check("frames3", int'(frame_cnt), 3);
      check("frames3_lock", int'(locked), 1);
      check("clean_err_h", int'(err_h), 0);
      check("clean_err_v", int'(err_v), 0);

      // Shortened line
      advance_to(0, 5);
      line_len = HT - 1;
      advance_to(0, 6);
      check("short_err_h", int'(err_h), 1);
      check("short_lock", int'(locked), 0);
      check("short_err_v", int'(err_v), 0);
      advance_to(0, 0);
      check("short_relock", int'(locked), 1);
      check("short_err_hold", int'(err_h), 1);
      check("short_frame", int'(frame_cnt), 3);
      clear_errors();
      check("clr_err_h", int'(err_h), 0);

      // Narrow hsync pulse, cleared on the same sample: set must win
      advance_to(HS - 2, 7);
      hs_w = HS - 1;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("narrow_err_h", int'(err_h), 1);
      check("narrow_lock", int'(locked), 0);
      advance_to(0, 0);
      check("narrow_relock", int'(locked), 1);
      clear_errors();
      check("clr2_err_h", int'(err_h), 0);

      // Frame one line short
      frame_len = VT - 1;
      advance_to(0, 0);
      check("vshort_err_v", int'(err_v), 1);
      check("vshort_lock", int'(locked), 0);
      check("vshort_err_h", int'(err_h), 0);
      advance_to(0, 0);
      check("vshort_relock", int'(locked), 1);
      clear_errors();
      check("clr_err_v", int'(err_v), 0);

      // vsync fall away from an hsync fall
      advance_to(20, 8);
      vs_glitch = 1'b1;
      step();
      vs_glitch = 1'b0;
      check("glitch_err_v", int'(err_v), 1);
      check("glitch_lock", int'(locked), 0);
      check("glitch_err_h", int'(err_h), 0);
      advance_to(0, 0);
      check("glitch_relock", int'(locked), 1);
      advance_to(0, 0);
      check("frames4", int'(frame_cnt), 4);

      // Reset pulse in the active region, coincident with a pix_en sample
      advance_to(15, 6);
      check("mid_x", int'(x), 15 - HST);
      check("mid_y", int'(y), 6 - VST);
      clr = 1'b0;
      step();
      clr = 1'b1;
      check("mrst_locked", int'(locked), 0);
      check("mrst_active", int'(active), 0);
      check("mrst_x", int'(x), 0);
      check("mrst_y", int'(y), 0);
      check("mrst_frame", int'(frame_cnt), 0);
      check("mrst_err_v", int'(err_v), 0);
      advance_to(0, 8);
      check("reacq_lock0", int'(locked), 0);
      advance_to(39, 19);
      check("reacq_lock1", int'(locked), 0);
      step();
      check("reacq_lock", int'(locked), 1);
      check("reacq_frame", int'(frame_cnt), 0);
      advance_to(0, 0);
      check("reacq_frame1", int'(frame_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
